// File: rtl/regfile_param_if.sv
// Bus bundle for regfile_param: read, write, observe and clear-control signals.
// The register file owns the slave side; the core (or bench) owns the master side.
interface regfile_param_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] rd_addr_a;
   logic [DATA_W-1:0] rd_data_a;
   logic [ADDR_W-1:0] rd_addr_b;
   logic [DATA_W-1:0] rd_data_b;
   // Write port: no handshake. wr_en is sampled at every posedge. A write offered
   // while busy is high is discarded and flagged by wr_drop on the following cycle.
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [ADDR_W-1:0] obs_addr;
   logic [DATA_W-1:0] obs_data;
   logic              clr_req;
   logic              busy;
   logic              wr_drop;

   modport master (
      output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, obs_addr, clr_req,
      input  rd_data_a, rd_data_b, obs_data, busy, wr_drop
   );

   modport slave (
      input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, obs_addr, clr_req,
      output rd_data_a, rd_data_b, obs_data, busy, wr_drop
   );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file: two combinational read ports, one write port, one
// observe port, optional zero register and write-through bypass, sweeping clear engine.
module regfile_param #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic           clk,
   input  logic           reset,
   regfile_param_if.slave bus,
   output logic           dbg_state
);
   localparam int                DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST  = '1;

   typedef enum logic {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] clr_ptr, clr_ptr_nxt;
   logic              wr_drop_q;
   logic              clearing;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic              byp_a, byp_b;

   // Storage has no reset so it can map onto plain RAM; the sweep zeroes it.
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_CLEAR;
         clr_ptr   <= '0;
         wr_drop_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         clr_ptr   <= clr_ptr_nxt;
         wr_drop_q <= clearing & bus.wr_en;
      end
   end

   always_comb begin
      state_nxt   = state;
      clr_ptr_nxt = clr_ptr;
      clearing    = 1'b0;
      mem_we      = 1'b0;
      mem_waddr   = bus.wr_addr;
      mem_wdata   = bus.wr_data;
      case (state)
         ST_CLEAR: begin
            clearing  = 1'b1;
            mem_we    = 1'b1;
            mem_waddr = clr_ptr;
            mem_wdata = '0;
            // clr_req is deliberately not looked at here: a running sweep is never restarted.
            if (clr_ptr == LAST) begin
               state_nxt   = ST_IDLE;
               clr_ptr_nxt = '0;
            end else begin
               clr_ptr_nxt = clr_ptr + 1'b1;
            end
         end
         default: begin
            if (bus.wr_en && !(ZERO_REG && (bus.wr_addr == '0))) mem_we = 1'b1;
            if (bus.clr_req) begin
               state_nxt   = ST_CLEAR;
               clr_ptr_nxt = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   assign byp_a = BYPASS && bus.wr_en && (bus.rd_addr_a == bus.wr_addr);
   assign byp_b = BYPASS && bus.wr_en && (bus.rd_addr_b == bus.wr_addr);

   // Priority: sweep forces zero, then the hardwired zero entry, then bypass, then storage.
   always_comb begin
      bus.rd_data_a = mem[bus.rd_addr_a];
      if (clearing || (ZERO_REG && (bus.rd_addr_a == '0))) bus.rd_data_a = '0;
      else if (byp_a)                                      bus.rd_data_a = bus.wr_data;
   end

   always_comb begin
      bus.rd_data_b = mem[bus.rd_addr_b];
      if (clearing || (ZERO_REG && (bus.rd_addr_b == '0))) bus.rd_data_b = '0;
      else if (byp_b)                                      bus.rd_data_b = bus.wr_data;
   end

   always_comb begin
      bus.obs_data = mem[bus.obs_addr];
      if (clearing || (ZERO_REG && (bus.obs_addr == '0))) bus.obs_data = '0;
   end

   assign bus.busy    = clearing;
   assign bus.wr_drop = wr_drop_q;
   assign dbg_state   = state;
endmodule
